// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port 1024x32 data memory.
// Optional grant counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   lat_port;
  logic   lat_we;
  logic   any_req;
  logic   winner;

  // On contention the port that did not win last time is favoured.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 && req1) ? ~last_grant : ~req0;
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS: begin
        mem_we     = lat_we;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_we     <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_port   <= winner;
            last_grant <= winner;
            lat_we     <= winner ? we1 : we0;
            mem_a      <= winner ? addr1 : addr0;
            mem_wd     <= winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          // The ack register rises together with entry to RESP.
          if (lat_port) begin
            ack1 <= 1'b1;
            if (!lat_we) rdata1 <= mem_rd;
          end else begin
            ack0 <= 1'b1;
            if (!lat_we) rdata0 <= mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (state == IDLE && any_req) begin
      if (!winner && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (winner && gnt_cnt1 != 16'hFFFF)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1024x32 memory.
// Define DMEM_ARB_STATS_EN to also exercise the grant counters.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [9:0]  mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Each word preloads to A500_0000 | address so reads are recognisable.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
  end

  assign mem_rd = mem[mem_a];

  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [9:0] addr,
                               input logic [31:0] wdata);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic dropRequest(input int port);
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
  endtask

  // Grant at the first edge, ack visible after the second, back to IDLE after the third.
  task automatic doAccess(input int port, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, input string tag);
    applyStimulus(port, we, addr, wdata);
    tick();
    tick();
    checkOutput({tag, "_ack"}, {31'b0, (port == 0) ? ack0 : ack1}, 32'd1);
    checkOutput({tag, "_other_ack"}, {31'b0, (port == 0) ? ack1 : ack0}, 32'd0);
    dropRequest(port);
    tick();
  endtask

  initial begin
    logic [3:0] seq;
    int         n0, n1, overlap;

    rst = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    #12;
    checkOutput("rst_ack0",   {31'b0, ack0},   32'd0);
    checkOutput("rst_ack1",   {31'b0, ack1},   32'd0);
    checkOutput("rst_rdata0", rdata0,          32'd0);
    checkOutput("rst_rdata1", rdata1,          32'd0);
    checkOutput("rst_mem_a",  {22'b0, mem_a},  32'd0);
    checkOutput("rst_mem_wd", mem_wd,          32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] contention from reset");
    applyStimulus(0, 1'b0, 10'd5, 32'd0);
    applyStimulus(1, 1'b0, 10'd6, 32'd0);
    tick();
    checkOutput("cont_grant0_addr", {22'b0, mem_a}, 32'd5);
    checkOutput("cont_read_we",     {31'b0, mem_we}, 32'd0);
    checkOutput("cont_early_ack0",  {31'b0, ack0},  32'd0);
    tick();
    checkOutput("cont_ack0",   {31'b0, ack0}, 32'd1);
    checkOutput("cont_ack1_0", {31'b0, ack1}, 32'd0);
    checkOutput("cont_rdata0", rdata0,        32'hA500_0005);
    dropRequest(0);
    tick();
    checkOutput("cont_idle_ack0", {31'b0, ack0}, 32'd0);
    checkOutput("cont_idle_ack1", {31'b0, ack1}, 32'd0);
    tick();
    checkOutput("cont_grant1_addr", {22'b0, mem_a}, 32'd6);
    tick();
    checkOutput("cont_ack1",   {31'b0, ack1}, 32'd1);
    checkOutput("cont_ack0_1", {31'b0, ack0}, 32'd0);
    checkOutput("cont_rdata1", rdata1,        32'hA500_0006);
    dropRequest(1);
    tick();

    $display("[TB] round-robin");
    seq = '0; n0 = 0; n1 = 0; overlap = 0;
    applyStimulus(0, 1'b0, 10'd10, 32'd0);
    applyStimulus(1, 1'b0, 10'd11, 32'd0);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack0 && ack1) overlap++;
      if (ack0) begin seq = {seq[2:0], 1'b0}; n0++; end
      if (ack1) begin seq = {seq[2:0], 1'b1}; n1++; end
    end
    dropRequest(0);
    dropRequest(1);
    checkOutput("rr_acks0",   n0,            32'd2);
    checkOutput("rr_acks1",   n1,            32'd2);
    checkOutput("rr_order",   {28'b0, seq},  32'b0101);
    checkOutput("rr_overlap", overlap,       32'd0);
    checkOutput("rr_rdata0",  rdata0,        32'hA500_000A);
    checkOutput("rr_rdata1",  rdata1,        32'hA500_000B);
    tick();

    $display("[TB] port 0 write then read");
    applyStimulus(0, 1'b1, 10'd28, 32'hDEAD_BEEF);
    tick();
    checkOutput("wr_mem_we", {31'b0, mem_we}, 32'd1);
    checkOutput("wr_mem_a",  {22'b0, mem_a},  32'd28);
    checkOutput("wr_mem_wd", mem_wd,          32'hDEAD_BEEF);
    tick();
    checkOutput("wr_we_resp", {31'b0, mem_we}, 32'd0);
    checkOutput("wr_ack0",    {31'b0, ack0},   32'd1);
    dropRequest(0);
    tick();
    checkOutput("wr_ack_pulse", {31'b0, ack0},   32'd0);
    checkOutput("wr_we_idle",   {31'b0, mem_we}, 32'd0);
    checkOutput("wr_a_hold",    {22'b0, mem_a},  32'd28);
    doAccess(0, 1'b0, 10'd28, 32'd0, "rd28");
    checkOutput("rd28_rdata0", rdata0, 32'hDEAD_BEEF);

    $display("[TB] read isolation");
    doAccess(1, 1'b1, 10'd7, 32'h1234_5678, "wr7");
    checkOutput("wr7_rdata1_kept", rdata1, 32'hA500_000B);
    doAccess(0, 1'b0, 10'd7, 32'd0, "rd7");
    checkOutput("rd7_rdata0", rdata0, 32'h1234_5678);
    checkOutput("rd7_rdata1", rdata1, 32'hA500_000B);

    $display("[TB] reset during access");
    applyStimulus(0, 1'b1, 10'd9, 32'hAAAA_5555);
    tick();
    checkOutput("mr_we_access", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mr_we_dropped", {31'b0, mem_we}, 32'd0);
    checkOutput("mr_no_ack",     {31'b0, ack0},   32'd0);
    dropRequest(0);
    tick();
    checkOutput("mr_ack_held",  {31'b0, ack0},   32'd0);
    checkOutput("mr_we_held",   {31'b0, mem_we}, 32'd0);
    checkOutput("mr_mem_a_clr", {22'b0, mem_a},  32'd0);
    checkOutput("mr_rdata0_clr", rdata0,         32'd0);
    #2;
    rst = 1'b1;
    tick();
    doAccess(0, 1'b0, 10'd9, 32'd0, "rd9");
    checkOutput("rd9_rdata0", rdata0, 32'hA500_0009);

`ifdef DMEM_ARB_STATS_EN
    $display("[TB] grant counters");
    doAccess(0, 1'b0, 10'd1, 32'd0, "st0a");
    doAccess(0, 1'b0, 10'd1, 32'd0, "st0b");
    doAccess(1, 1'b0, 10'd2, 32'd0, "st1a");
    doAccess(1, 1'b0, 10'd2, 32'd0, "st1b");
    checkOutput("st_cnt0", {16'b0, gnt_cnt0}, 32'd3);
    checkOutput("st_cnt1", {16'b0, gnt_cnt1}, 32'd2);
    force dut.gnt_cnt0 = 16'hFFFF;
    #1;
    release dut.gnt_cnt0;
    doAccess(0, 1'b0, 10'd1, 32'd0, "st_sat");
    checkOutput("st_cnt0_sat", {16'b0, gnt_cnt0}, 32'h0000_FFFF);
    checkOutput("st_cnt1_kept", {16'b0, gnt_cnt1}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
